// File: rtl/rx_dma_writer.sv
// rx_dma_writer: turns PHY FIFO frames (phy_*) into master write commands (mst_*) on a host ring (dma_*), writing the header last, with frame_intr and drop_count status
module rx_dma_writer #(
  parameter int          CHUNK_DW  = 16,
  parameter logic [15:0] HDR_MAGIC = 16'h5555
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [17:0] phy_dout,
  input  logic        phy_empty,
  output logic        phy_rd_en,
  output logic [17:0] mst_din,
  input  logic        mst_full,
  output logic        mst_wr_en,
  input  logic        dma_enable,
  input  logic [29:0] dma_addr_start,
  input  logic [19:0] dma_length,
  output logic [29:0] dma_addr_cur,
  output logic        frame_intr,
  output logic [15:0] drop_count
);
  localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, CMD = 3'd2, DATA = 3'd3, HDR = 3'd4, DROP = 3'd5;
  localparam logic [5:0] CHUNK = 6'(CHUNK_DW);
  logic [2:0] state;
  logic rd_pend, en_q, eof_seen;
  logic [5:0] wcnt, wn, idx, len, last_idx;
  logic [29:0] frame_start, data_addr, ring_end, slot_next, first_data, adv, addr;
  logic [15:0] byte_len;
  logic [15:0] buf_mem [2*CHUNK_DW];
  logic sof, eof, new_frame, abort, reject, drop_end, flush, hdr, last;
  logic [16:0] drop_sum;
  logic [17:0] cmd_word;
  always_comb begin
    sof        = phy_dout[17];
    eof        = phy_dout[16];
    ring_end   = dma_addr_start + 30'(dma_length);
    slot_next  = dma_addr_cur + 30'd1;
    first_data = slot_next == ring_end ? dma_addr_start : slot_next;
    wn         = wcnt + 6'd1;
    flush      = eof || (!wn[0] && ({1'b0, wn[5:1]} == CHUNK || data_addr + 30'(wn[5:1]) == ring_end));
    adv        = data_addr + 30'(len);
    last_idx   = {len[4:0], 1'b0} - 6'd1;
    new_frame  = rd_pend && (state == IDLE || (state == FILL && sof));
    abort      = rd_pend && state == FILL && sof;
    reject     = !(sof && dma_enable);
    drop_end   = eof && ((rd_pend && state == DROP) || (new_frame && reject));
    drop_sum   = {1'b0, drop_count} + 17'(abort) + 17'(drop_end);
    hdr        = state == HDR;
    addr       = hdr ? frame_start : data_addr;
    last       = idx == (hdr ? 6'd4 : state == CMD ? 6'd2 : last_idx);
    mst_wr_en  = (state == CMD || state == DATA || hdr) && !mst_full;
    cmd_word   = idx == 6'd0 ? {2'b10, 11'h0, hdr ? 5'd1 : len[4:0]} :
                 idx == 6'd1 ? {2'b00, addr[29:14]} :
                 idx == 6'd2 ? {2'b00, addr[13:0], 2'b00} :
                 idx == 6'd3 ? {2'b00, byte_len} : {2'b01, HDR_MAGIC};
    mst_din    = state == DATA ? {1'b0, last, idx < wcnt ? buf_mem[idx[4:0]] : 16'h0} :
                 (state == CMD || hdr) ? cmd_word : 18'h0;
  end
  always_ff @(posedge sys_clk) begin
    if (rd_pend && (state == IDLE || state == FILL)) buf_mem[new_frame ? 5'd0 : wcnt[4:0]] <= phy_dout[15:0];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      rd_pend      <= 1'b0;
      en_q         <= 1'b0;
      eof_seen     <= 1'b0;
      wcnt         <= 6'd0;
      idx          <= 6'd0;
      len          <= 6'd0;
      frame_start  <= 30'd0;
      data_addr    <= 30'd0;
      byte_len     <= 16'd0;
      phy_rd_en    <= 1'b0;
      dma_addr_cur <= 30'd0;
      frame_intr   <= 1'b0;
      drop_count   <= 16'd0;
    end else begin
      en_q       <= dma_enable;
      frame_intr <= 1'b0;
      rd_pend    <= phy_rd_en;
      phy_rd_en  <= (state == IDLE || state == FILL || state == DROP) && !phy_empty && !phy_rd_en && !rd_pend;
      if (abort || drop_end) drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (new_frame) begin
        if (reject) state <= eof ? IDLE : DROP;
        else begin
          frame_start <= dma_addr_cur;
          data_addr   <= first_data;
          byte_len    <= 16'd2;
          wcnt        <= 6'd1;
          len         <= 6'd1;
          eof_seen    <= eof;
          idx         <= 6'd0;
          state       <= eof ? CMD : FILL;
        end
      end else if (rd_pend && state == FILL) begin
        wcnt     <= wn;
        byte_len <= byte_len + 16'd2;
        eof_seen <= eof;
        if (flush) begin
          len   <= 6'(wn[5:1]) + 6'(wn[0]);
          idx   <= 6'd0;
          state <= CMD;
        end
      end else if (rd_pend && state == DROP && eof) state <= IDLE;
      if (mst_wr_en) begin
        idx <= last ? 6'd0 : idx + 6'd1;
        if (last && state == CMD) state <= DATA;
        if (last && state == DATA) begin
          wcnt      <= 6'd0;
          data_addr <= adv == ring_end ? dma_addr_start : adv;
          state     <= eof_seen ? HDR : FILL;
        end
        if (last && hdr) begin
          state        <= IDLE;
          frame_intr   <= 1'b1;
          dma_addr_cur <= data_addr;
        end
      end
      if (dma_enable && !en_q) dma_addr_cur <= dma_addr_start;
    end
  end
endmodule

// File: tb/tb_rx_dma_writer.sv
// tb_rx_dma_writer: directed checks of rx_dma_writer command streams, ring wrap, drops and stalls
module tb_rx_dma_writer;
  logic sys_clk, sys_rst_n, phy_empty, phy_rd_en, mst_full, mst_wr_en, dma_enable, frame_intr;
  logic [17:0] phy_dout, mst_din;
  logic [29:0] dma_addr_start, dma_addr_cur;
  logic [19:0] dma_length;
  logic [15:0] drop_count;
  logic [17:0] phy_q[$], got[$], exp_q[$];
  int checks = 0, errors = 0, intr_cnt = 0, empty_viol = 0, full_viol = 0;
  bit stall_mode = 0, rd_req = 0;
  rx_dma_writer dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .phy_dout(phy_dout), .phy_empty(phy_empty),
    .phy_rd_en(phy_rd_en), .mst_din(mst_din), .mst_full(mst_full), .mst_wr_en(mst_wr_en),
    .dma_enable(dma_enable), .dma_addr_start(dma_addr_start), .dma_length(dma_length),
    .dma_addr_cur(dma_addr_cur), .frame_intr(frame_intr), .drop_count(drop_count)
  );
  initial sys_clk = 0;
  always #4 sys_clk = ~sys_clk;
  task automatic tick();
    @(negedge sys_clk);
    rd_req = phy_rd_en;
    if (rd_req && phy_empty) empty_viol++;
    if (mst_wr_en) begin
      if (mst_full) full_viol++;
      else got.push_back(mst_din);
    end
    if (frame_intr) intr_cnt++;
    @(posedge sys_clk);
    #1;
    if (rd_req && phy_q.size() > 0) phy_dout = phy_q.pop_front();
    phy_empty = phy_q.size() == 0;
    mst_full = stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask
  task automatic push_frame(input int n, input logic [15:0] base, input bit sof = 1'b1, input bit eof = 1'b1);
    for (int i = 0; i < n; i++) phy_q.push_back({sof && i == 0, eof && i == n - 1, 16'(base + 16'(i))});
    phy_empty = phy_q.size() == 0;
  endtask
  task automatic exp_write(input logic [31:0] a, input int ndw, input logic [15:0] base, input int w0, input int nw);
    exp_q.push_back({2'b10, 11'h0, 5'(ndw)});
    exp_q.push_back({2'b00, a[31:16]});
    exp_q.push_back({2'b00, a[15:2], 2'b00});
    for (int i = 0; i < 2 * ndw; i++)
      exp_q.push_back({1'b0, i == 2 * ndw - 1, (w0 + i < nw) ? 16'(base + 16'(w0 + i)) : 16'h0000});
  endtask
  task automatic exp_hdr(input logic [31:0] a, input logic [15:0] blen);
    exp_q.push_back({2'b10, 11'h0, 5'd1});
    exp_q.push_back({2'b00, a[31:16]});
    exp_q.push_back({2'b00, a[15:2], 2'b00});
    exp_q.push_back({2'b00, blen});
    exp_q.push_back({2'b01, 16'h5555});
  endtask
  task automatic drain(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 40 && n < 8000) begin
      tick();
      n++;
      quiet = (!phy_rd_en && !mst_wr_en && phy_q.size() == 0) ? quiet + 1 : 0;
    end
    chk({tag, "_settle"}, 32'(quiet >= 40), 32'd1);
  endtask
  task automatic check_stream(input string tag);
    int first = -1;
    chk({tag, "_words"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (first < 0 && got[i] !== exp_q[i]) first = i;
    checks++;
    assert (first < 0) else begin
      errors++;
      $error("FAIL %s_stream: word %0d got %05h expected %05h", tag, first, got[first], exp_q[first]);
    end
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    sys_rst_n = 0; phy_dout = 0; phy_empty = 1; mst_full = 0; dma_enable = 0;
    dma_addr_start = 30'h0400_0000; dma_length = 20'h10000;
    repeat (3) tick();
    chk("rst_rd_en", phy_rd_en, 0);
    chk("rst_wr_en", mst_wr_en, 0);
    chk("rst_din", mst_din, 0);
    chk("rst_intr", frame_intr, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_cur", dma_addr_cur, 0);
    sys_rst_n = 1;
    dma_enable = 1;
    repeat (2) tick();
    chk("enable_load", dma_addr_cur, 30'h0400_0000);
    intr_cnt = 0;
    push_frame(32, 16'h1000);
    exp_write(32'h1000_0004, 16, 16'h1000, 0, 32);
    exp_hdr(32'h1000_0000, 16'h0040);
    drain("f32");
    check_stream("f32");
    chk("f32_intr", intr_cnt, 1);
    chk("f32_cur", dma_addr_cur, 30'h0400_0011);
    intr_cnt = 0;
    push_frame(31, 16'h2000);
    exp_write(32'h1000_0048, 16, 16'h2000, 0, 31);
    exp_hdr(32'h1000_0044, 16'h003E);
    drain("odd31");
    check_stream("odd31");
    chk("odd31_intr", intr_cnt, 1);
    chk("odd31_cur", dma_addr_cur, 30'h0400_0022);
    dma_enable = 0;
    tick();
    dma_addr_start = 30'h0400_003C;
    dma_length = 20'h40;
    dma_enable = 1;
    repeat (2) tick();
    dma_addr_start = 30'h0400_0000;
    tick();
    chk("wrap_cur_in", dma_addr_cur, 30'h0400_003C);
    intr_cnt = 0;
    push_frame(16, 16'h5000);
    exp_write(32'h1000_00F4, 3, 16'h5000, 0, 16);
    exp_write(32'h1000_0000, 5, 16'h5000, 6, 16);
    exp_hdr(32'h1000_00F0, 16'h0020);
    drain("wrap");
    check_stream("wrap");
    chk("wrap_intr", intr_cnt, 1);
    chk("wrap_cur", dma_addr_cur, 30'h0400_0005);
    intr_cnt = 0;
    push_frame(4, 16'h3000, 1'b1, 1'b0);
    push_frame(6, 16'h4000);
    exp_write(32'h1000_0018, 3, 16'h4000, 0, 6);
    exp_hdr(32'h1000_0014, 16'h000C);
    drain("sof_mid");
    check_stream("sof_mid");
    chk("sof_mid_drop", drop_count, 1);
    chk("sof_mid_intr", intr_cnt, 1);
    chk("sof_mid_cur", dma_addr_cur, 30'h0400_0009);
    intr_cnt = 0;
    stall_mode = 1;
    push_frame(100, 16'h6000);
    exp_write(32'h1000_0028, 16, 16'h6000, 0, 100);
    exp_write(32'h1000_0068, 16, 16'h6000, 32, 100);
    exp_write(32'h1000_00A8, 16, 16'h6000, 64, 100);
    exp_write(32'h1000_00E8, 2, 16'h6000, 96, 100);
    exp_hdr(32'h1000_0024, 16'h00C8);
    drain("stall");
    stall_mode = 0;
    mst_full = 0;
    check_stream("stall");
    chk("stall_intr", intr_cnt, 1);
    chk("stall_cur", dma_addr_cur, 30'h0400_003C);
    intr_cnt = 0;
    dma_enable = 0;
    push_frame(4, 16'h7000);
    push_frame(3, 16'h7100);
    drain("disabled");
    check_stream("disabled");
    chk("disabled_drop", drop_count, 3);
    chk("disabled_fifo_left", phy_q.size(), 0);
    chk("disabled_intr", intr_cnt, 0);
    chk("disabled_cur", dma_addr_cur, 30'h0400_003C);
    dma_enable = 1;
    repeat (2) tick();
    chk("reenable_cur", dma_addr_cur, 30'h0400_0000);
    phy_q.push_back({2'b01, 16'hDEAD});
    phy_empty = 0;
    drain("stray");
    chk("stray_drop", drop_count, 4);
    intr_cnt = 0;
    push_frame(2, 16'h8000);
    repeat (10) tick();
    dma_enable = 0;
    exp_write(32'h1000_0004, 1, 16'h8000, 0, 2);
    exp_hdr(32'h1000_0000, 16'h0004);
    drain("late_off");
    check_stream("late_off");
    chk("late_off_intr", intr_cnt, 1);
    chk("late_off_cur", dma_addr_cur, 30'h0400_0002);
    chk("no_rd_when_empty", empty_viol, 0);
    chk("no_wr_when_full", full_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
